// File: rtl/cc_register_bank_if.sv
// cc_register_bank_if: write/read/status bundle between the datapath control and the register bank
interface cc_register_bank_if #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_DECODER_OUT = 38,
  parameter int DATAWIDTH_DECODER_SELECTION = 6
);
  logic [DATAWIDTH_DECODER_OUT-1:0] load;
  logic [DATAWIDTH_BUS-1:0] data;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] sel_a;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] sel_b;
  logic clr_err;
  logic [DATAWIDTH_BUS-1:0] data_a;
  logic [DATAWIDTH_BUS-1:0] data_b;
  logic wr_ack;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] last_idx;
  logic error;
  modport master (
    output load, data, sel_a, sel_b, clr_err,
    input data_a, data_b, wr_ack, last_idx, error
  );
  modport slave (
    input load, data, sel_a, sel_b, clr_err,
    output data_a, data_b, wr_ack, last_idx, error
  );
endinterface

// File: rtl/cc_register_bank.sv
// cc_register_bank: 38-entry register file with one-hot writes, two combinational read ports and multi-hot error flag; CC_REGISTER_BANK_BYPASS_EN enables write-through forwarding
module cc_register_bank #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_DECODER_OUT = 38,
  parameter int DATAWIDTH_DECODER_SELECTION = 6
) (
  input logic cc_register_bank_CLOCK_50,
  input logic cc_register_bank_RESET_InHigh,
  cc_register_bank_if.slave bus
);
  localparam int W = DATAWIDTH_BUS;
  localparam int N = DATAWIDTH_DECODER_OUT;
  localparam int S = DATAWIDTH_DECODER_SELECTION;
  logic clk;
  logic rst;
  logic [W-1:0] regs [N];
  logic [N-1:0] ld;
  logic multi;
  logic one_hot;
  logic [S-1:0] idx;
  logic [W-1:0] rd_a;
  logic [W-1:0] rd_b;
  logic wr_ack;
  logic [S-1:0] last_idx;
  logic error;
  assign clk = cc_register_bank_CLOCK_50;
  assign rst = cc_register_bank_RESET_InHigh;
  assign ld = bus.load & ~N'(1);
  assign multi = |(ld & (ld - N'(1)));
  assign one_hot = |ld && !multi;
  // encode the single set load bit into a register index
  always_comb begin
    idx = '0;
    for (int k = 1; k < N; k++)
      if (ld[k]) idx = k[S-1:0];
  end
  assign rd_a = (bus.sel_a != '0 && int'(bus.sel_a) < N) ? regs[bus.sel_a] : '0;
  assign rd_b = (bus.sel_b != '0 && int'(bus.sel_b) < N) ? regs[bus.sel_b] : '0;
`ifdef CC_REGISTER_BANK_BYPASS_EN
  assign bus.data_a = (!rst && one_hot && bus.sel_a == idx) ? bus.data : rd_a;
  assign bus.data_b = (!rst && one_hot && bus.sel_b == idx) ? bus.data : rd_b;
`else
  assign bus.data_a = rd_a;
  assign bus.data_b = rd_b;
`endif
  // register array: only a clean one-hot load writes; entry 0 stays zero
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int r = 0; r < N; r++) regs[r] <= '0;
    else
      for (int r = 1; r < N; r++)
        if (one_hot && ld[r]) regs[r] <= bus.data;
  // acknowledge, last written index and sticky multi-hot flag (set beats clear)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ack <= 1'b0;
      last_idx <= '0;
      error <= 1'b0;
    end else begin
      wr_ack <= one_hot;
      last_idx <= one_hot ? idx : last_idx;
      error <= multi ? 1'b1 : (bus.clr_err ? 1'b0 : error);
    end
  assign bus.wr_ack = wr_ack;
  assign bus.last_idx = last_idx;
  assign bus.error = error;
endmodule

// File: tb/tb_cc_register_bank.sv
// tb_cc_register_bank: scoreboard-driven bench for cc_register_bank
module tb_cc_register_bank;
  typedef struct {
    string name;
    logic [31:0] exp;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [31:0] got[$];
  cc_register_bank_if bus ();
  cc_register_bank dut (
    .cc_register_bank_CLOCK_50(clk),
    .cc_register_bank_RESET_InHigh(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  task automatic expect_v(input string n, input logic [31:0] v);
    sb.push_back('{n, v});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int k, input logic [31:0] d);
    bus.load = 38'd1 << k;
    bus.data = d;
  endtask
  task automatic test_reset();
    expect_v("rst_wr_ack", 0);
    expect_v("rst_last_idx", 0);
    expect_v("rst_error", 0);
    expect_v("rst_read5", 0);
    expect_v("pre_wr_ack", 1);
    expect_v("pre_last_idx", 5);
    expect_v("pre_read5", 32'h55);
    expect_v("async_wr_ack", 0);
    expect_v("async_last_idx", 0);
    expect_v("async_read5", 0);
    expect_v("post_read5", 0);
    expect_v("post_wr_ack", 0);
    expect_v("post_last_idx", 0);
    bus.sel_a = 6'd5;
    #1;
    got.push_back(32'(bus.wr_ack));
    got.push_back(32'(bus.last_idx));
    got.push_back(32'(bus.error));
    got.push_back(bus.data_a);
    step();
    rst = 1'b0;
    drive(5, 32'h55);
    step();
    bus.load = '0;
    #1;
    got.push_back(32'(bus.wr_ack));
    got.push_back(32'(bus.last_idx));
    got.push_back(bus.data_a);
    drive(5, 32'hDEADBEEF);
    #2;
    rst = 1'b1;
    #1;
    got.push_back(32'(bus.wr_ack));
    got.push_back(32'(bus.last_idx));
    got.push_back(bus.data_a);
    step();
    rst = 1'b0;
    bus.load = '0;
    #1;
    got.push_back(bus.data_a);
    got.push_back(32'(bus.wr_ack));
    got.push_back(32'(bus.last_idx));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = got.pop_front();
      checks++;
      if (o !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask
  task automatic test_single_write();
    drive(7, 32'h12345678);
    expect_v("sw_wr_ack", 1);
    expect_v("sw_last_idx", 7);
    expect_v("sw_read_a", 32'h12345678);
    expect_v("sw_read_b", 32'h12345678);
    expect_v("sw_wr_ack_drop", 0);
    expect_v("sw_last_idx_hold", 7);
    step();
    got.push_back(32'(bus.wr_ack));
    got.push_back(32'(bus.last_idx));
    bus.load = '0;
    bus.sel_a = 6'd7;
    bus.sel_b = 6'd7;
    #1;
    got.push_back(bus.data_a);
    got.push_back(bus.data_b);
    step();
    got.push_back(32'(bus.wr_ack));
    got.push_back(32'(bus.last_idx));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = got.pop_front();
      checks++;
      if (o !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask
  task automatic test_reg0_range();
    bus.load = 38'd1;
    bus.data = 32'hFFFFFFFF;
    expect_v("r0_wr_ack", 0);
    expect_v("r0_error", 0);
    expect_v("r0_last_idx", 7);
    expect_v("r0_read0", 0);
    expect_v("r0_read40", 0);
    expect_v("r0_read7_kept", 32'h12345678);
    step();
    got.push_back(32'(bus.wr_ack));
    got.push_back(32'(bus.error));
    got.push_back(32'(bus.last_idx));
    bus.load = '0;
    bus.sel_a = 6'd0;
    bus.sel_b = 6'd40;
    #1;
    got.push_back(bus.data_a);
    got.push_back(bus.data_b);
    bus.sel_b = 6'd7;
    #1;
    got.push_back(bus.data_b);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = got.pop_front();
      checks++;
      if (o !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask
  task automatic test_multi_hot();
    drive(3, 32'h33);
    step();
    drive(9, 32'h99);
    step();
    bus.load = (38'd1 << 3) | (38'd1 << 9);
    bus.data = 32'hA5A5A5A5;
    expect_v("mh_error", 1);
    expect_v("mh_wr_ack", 0);
    expect_v("mh_last_idx", 9);
    expect_v("mh_reg3", 32'h33);
    expect_v("mh_reg9", 32'h99);
    expect_v("mh_sticky", 1);
    expect_v("mh_clr_and_set", 1);
    expect_v("mh_cleared", 0);
    expect_v("b0_wr_ack", 1);
    expect_v("b0_error", 0);
    expect_v("b0_reg2", 32'h22);
    step();
    got.push_back(32'(bus.error));
    got.push_back(32'(bus.wr_ack));
    got.push_back(32'(bus.last_idx));
    bus.load = '0;
    bus.sel_a = 6'd3;
    bus.sel_b = 6'd9;
    #1;
    got.push_back(bus.data_a);
    got.push_back(bus.data_b);
    step();
    got.push_back(32'(bus.error));
    bus.load = (38'd1 << 20) | (38'd1 << 37);
    bus.clr_err = 1'b1;
    step();
    got.push_back(32'(bus.error));
    bus.load = '0;
    step();
    got.push_back(32'(bus.error));
    bus.clr_err = 1'b0;
    bus.load = 38'd1 | (38'd1 << 2);
    bus.data = 32'h22;
    step();
    got.push_back(32'(bus.wr_ack));
    got.push_back(32'(bus.error));
    bus.load = '0;
    bus.sel_a = 6'd2;
    #1;
    got.push_back(bus.data_a);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = got.pop_front();
      checks++;
      if (o !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask
  task automatic test_same_cycle();
    drive(4, 32'h1);
    step();
    drive(4, 32'h2);
    bus.sel_a = 6'd4;
    bus.sel_b = 6'd4;
`ifdef CC_REGISTER_BANK_BYPASS_EN
    expect_v("sc_before_a", 32'h2);
    expect_v("sc_before_b", 32'h2);
`else
    expect_v("sc_before_a", 32'h1);
    expect_v("sc_before_b", 32'h1);
`endif
    expect_v("sc_after_a", 32'h2);
    expect_v("sc_after_b", 32'h2);
    #1;
    got.push_back(bus.data_a);
    got.push_back(bus.data_b);
    step();
    bus.load = '0;
    #1;
    got.push_back(bus.data_a);
    got.push_back(bus.data_b);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = got.pop_front();
      checks++;
      if (o !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask
  task automatic test_back_to_back();
    int idx[3] = '{37, 37, 1};
    logic [31:0] val[3] = '{32'hC, 32'hD, 32'hE};
    for (int i = 0; i < 3; i++) begin
      drive(idx[i], val[i]);
      expect_v($sformatf("b2b_wr_ack%0d", i), 1);
      expect_v($sformatf("b2b_last_idx%0d", i), 32'(idx[i]));
      step();
      got.push_back(32'(bus.wr_ack));
      got.push_back(32'(bus.last_idx));
    end
    bus.load = '0;
    bus.sel_a = 6'd37;
    bus.sel_b = 6'd1;
    expect_v("b2b_reg37", 32'hD);
    expect_v("b2b_reg1", 32'hE);
    expect_v("b2b_wr_ack_end", 0);
    #1;
    got.push_back(bus.data_a);
    got.push_back(bus.data_b);
    step();
    got.push_back(32'(bus.wr_ack));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = got.pop_front();
      checks++;
      if (o !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask
  initial begin
    bus.load = '0;
    bus.data = '0;
    bus.sel_a = '0;
    bus.sel_b = '0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_reg0_range();
    test_multi_hot();
    test_same_cycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
